// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV registers behind a busdev
// decoder, a small transmit FIFO and a start/data/stop serialiser.
module uart_tx_dev #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        deven,
    input  logic [31:0] devaddr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        tx,
    output logic        idle
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t         state, state_nxt;
    logic [15:0]    div_q;
    logic [15:0]    cnt, cnt_nxt;
    logic [2:0]     bit_idx, bit_idx_nxt;
    logic [7:0]     shift, shift_nxt;
    logic           tx_nxt;
    logic           pop;

    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           empty, full, ovf, busy;

    logic [1:0]     reg_sel;
    logic           wr_acc, push_req, push_ok;
    logic           unused_bits;

    assign reg_sel     = devaddr[3:2];
    assign wr_acc      = deven & we;
    assign push_req    = wr_acc & (reg_sel == 2'd0);
    assign empty       = (count == '0);
    assign full        = (count == CW'(FIFO_DEPTH));
    assign busy        = (state != S_IDLE);
    assign idle        = empty & ~busy;
    assign unused_bits = ^{devaddr[31:4], devaddr[1:0], wdata[31:16]};

    // A push into a full FIFO still fits when the serialiser pops in the same cycle.
    assign push_ok = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf    <= 1'b0;
            div_q  <= DIV_RESET;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            if (push_req & full & ~pop)
                ovf <= 1'b1;
            else if (wr_acc & (reg_sel == 2'd1) & wdata[3])
                ovf <= 1'b0;

            if (wr_acc & (reg_sel == 2'd2))
                div_q <= wdata[15:0];

            rvalid <= deven & ~we;
            if (deven & ~we) begin
                case (reg_sel)
                    2'd1:    rdata <= {28'b0, ovf, busy, empty, full};
                    2'd2:    rdata <= {16'b0, div_q};
                    default: rdata <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            tx      <= tx_nxt;
        end
    end

    // The bit counter reloads from DIV only at bit starts, so DIV writes land on the next bit.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        tx_nxt      = tx;
        pop         = 1'b0;
        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr];
                    tx_nxt    = 1'b0;
                    cnt_nxt   = div_q;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    tx_nxt      = shift[0];
                    bit_idx_nxt = '0;
                    cnt_nxt     = div_q;
                    state_nxt   = S_DATA;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    cnt_nxt = div_q;
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = S_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shift_nxt   = {1'b0, shift[7:1]};
                        tx_nxt      = shift[1];
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_mem[rd_ptr];
                        tx_nxt    = 1'b0;
                        cnt_nxt   = div_q;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev: register access, frame timing, FIFO overflow,
// mid-bit divisor change and asynchronous reset, checked against a frame-level model.
module tb_uart_tx_dev;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        deven;
    logic [31:0] devaddr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        tx;
    logic        idle;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    logic [7:0] ob [6];
    logic [7:0] rb [4];
    int         rn, rd;
    logic       acc;

    always #5 clk = ~clk;

    uart_tx_dev #(.FIFO_DEPTH(4), .DIV_RESET(16'd433)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .deven   (deven),
        .devaddr (devaddr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .tx      (tx),
        .idle    (idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] status_word(input bit o, input bit b, input bit e, input bit f);
        return {28'b0, o, b, e, f};
    endfunction

    // Every task starts and ends on a falling edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        deven = 1'b1; we = 1'b1; devaddr = addr; wdata = data;
        @(negedge clk);
        deven = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        deven = 1'b1; we = 1'b0; devaddr = addr; wdata = '0;
        @(negedge clk);
        deven = 1'b0;
        check({tag, "_rvalid"}, rvalid, 1);
        check({tag, "_rdata"}, rdata, exp);
    endtask

    // Each bit is summarised by the AND and OR of its samples; a stable bit of the right
    // length makes both equal the expected frame {stop, data, start}.
    task automatic watch_frames(input int n, input int first_len, input int len, input string tag);
        logic [7:0] b;
        logic [9:0] exp_w, w_and, w_or;
        int         l;
        for (int f = 0; f < n; f++) begin
            b     = exp_q.pop_front();
            exp_w = {1'b1, b, 1'b0};
            w_and = '1;
            w_or  = '0;
            for (int i = 0; i < 10; i++) begin
                l = (f == 0 && i == 0) ? first_len : len;
                for (int c = 0; c < l; c++) begin
                    @(negedge clk);
                    w_and[i] = w_and[i] & tx;
                    w_or[i]  = w_or[i] | tx;
                    if (i == 0 && c == 0)
                        check($sformatf("%s%0d_busy", tag, f), idle, 0);
                end
            end
            check($sformatf("%s%0d_lo", tag, f), w_and, exp_w);
            check($sformatf("%s%0d_hi", tag, f), w_or, exp_w);
        end
    endtask

    initial begin
        n_rst = 1'b0; deven = 1'b0; we = 1'b0; devaddr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_idle", idle, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        n_rst = 1'b1;
        @(negedge clk);

        bus_read(32'h8, 32'd433, "div_rst");
        @(negedge clk);
        check("div_rst_rvalid_drop", rvalid, 0);
        bus_write(32'h8, 32'h1234);
        bus_read(32'h8, 32'h1234, "div_rw");
        bus_read(32'hC, 32'h0, "rsvd");
        bus_read(32'h0, 32'h0, "data_rd");
        bus_read(32'h4, status_word(0, 0, 1, 0), "stat_idle");

        // Single frame, 4-cycle bits.
        bus_write(32'h8, 32'd3);
        exp_q.push_back(8'h55);
        bus_write(32'h0, 32'h55);
        check("t1_pre_tx", tx, 1);
        watch_frames(1, 4, 4, "t1_");
        @(negedge clk);
        check("t1_idle", idle, 1);
        check("t1_tx_idle", tx, 1);

        // Three back-to-back frames, 2-cycle bits.
        bus_write(32'h8, 32'd1);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'hFF);
        fork
            begin
                bus_write(32'h0, 32'hA5);
                bus_write(32'h0, 32'h01);
                bus_write(32'h0, 32'hFF);
            end
            begin
                @(negedge clk);
                watch_frames(3, 2, 2, "t2_");
            end
        join
        @(negedge clk);
        check("t2_idle", idle, 1);

        // DIV changed from 9 to 2 during the start bit.
        bus_write(32'h8, 32'd9);
        exp_q.push_back(8'h3C);
        bus_write(32'h0, 32'h3C);
        check("t3_pre_tx", tx, 1);
        fork
            watch_frames(1, 10, 3, "t3_");
            begin
                repeat (4) @(negedge clk);
                bus_write(32'h8, 32'd2);
            end
        join
        @(negedge clk);
        check("t3_idle", idle, 1);
        bus_read(32'h8, 32'd2, "t3_div");

        // Random bursts at random divisors.
        for (int it = 0; it < 4; it++) begin
            rd = $urandom_range(1, 6);
            rn = $urandom_range(1, 4);
            bus_write(32'h8, rd);
            bus_read(32'h8, rd, "rnd_div");
            for (int j = 0; j < rn; j++) begin
                rb[j] = 8'($urandom);
                exp_q.push_back(rb[j]);
            end
            fork
                begin
                    for (int j = 0; j < rn; j++)
                        bus_write(32'h0, {24'b0, rb[j]});
                end
                begin
                    @(negedge clk);
                    watch_frames(rn, rd + 1, rd + 1, "rnd_");
                end
            join
            @(negedge clk);
            check("rnd_idle", idle, 1);
        end

        // Six rapid writes into a depth-4 FIFO: one popped, four queued, one dropped.
        bus_write(32'h8, 32'd100);
        ob[0] = 8'h00;
        for (int j = 1; j < 6; j++) ob[j] = 8'($urandom);
        for (int j = 0; j < 5; j++) exp_q.push_back(ob[j]);
        fork
            begin
                for (int j = 0; j < 6; j++)
                    bus_write(32'h0, {24'b0, ob[j]});
                bus_read(32'h4, status_word(1, 1, 0, 1), "ovf_stat");
                bus_write(32'h4, 32'h8);
                bus_read(32'h4, status_word(0, 1, 0, 1), "ovf_clr");
                bus_write(32'h8, 32'd1);
            end
            begin
                @(negedge clk);
                watch_frames(5, 101, 2, "ovf_");
            end
        join
        @(negedge clk);
        check("ovf_idle", idle, 1);

        // Asynchronous reset in the middle of a data bit.
        bus_write(32'h8, 32'd20);
        bus_write(32'h0, 32'h00);
        repeat (30) @(negedge clk);
        check("arst_pre_tx", tx, 0);
        #2 n_rst = 1'b0;
        #1;
        check("arst_tx", tx, 1);
        check("arst_idle", idle, 1);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        bus_read(32'h4, status_word(0, 0, 1, 0), "arst_stat");
        bus_read(32'h8, 32'd433, "arst_div");
        acc = 1'b1;
        repeat (300) begin
            @(negedge clk);
            acc = acc & tx & idle;
        end
        check("arst_quiet", acc, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_dev.md
# uart_tx_dev

Memory-mapped UART transmitter peripheral that sits directly downstream of a `busdev` address decoder. It consumes the decoder's one-cycle `deven` pulse and device-relative `devaddr`, plus the core's write qualifier and write data. Bytes written to it are queued in a small FIFO and serialised 8N1 on `tx`. Status and divisor registers are readable over the same access path.

## Interface
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, ≥2.
- `DIV_RESET`, 16'd433: reset value of DIV; bit period = DIV+1 clocks (434 = 115200 Bd at 50 MHz).

Ports:
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `deven`  in  1  one-cycle device select from the decoder.
- `devaddr`  in  32  device-relative byte address; only `devaddr[3:2]` is decoded.
- `we`  in  1  1 = write, 0 = read; qualified by `deven`.
- `wdata`  in  32  write data; qualified by `deven & we`.
- `rdata`  out  32  registered read data.
- `rvalid`  out  1  one-cycle pulse; `rdata` is valid in that cycle.
- `tx`  out  1  serial line, idle high.
- `idle`  out  1  high when the FIFO is empty and the FSM is in IDLE.

## Operation
Register map (`devaddr[3:2]`):
- 0, DATA: write pushes `wdata[7:0]`; reads return 0.
- 1, STATUS: read returns {28'b0, ovf, busy, empty, full}.
  - `busy` = FSM not in IDLE.
  - Writing 1 to bit 3 clears `ovf`; other bits are ignored.
- 2, DIV: R/W, `wdata[15:0]`; reads return {16'b0, DIV}.
- 3: reserved. Reads return 0; writes are ignored.

FIFO:
- A write to DATA when full is dropped, FIFO contents are unchanged, and `ovf` is set sticky.
- Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`. Count is `$clog2(FIFO_DEPTH)+1` bits wide.

TX FSM (IDLE, START, DATA, STOP):
- A bit counter reloads from DIV at every bit start and counts down to 0. Each bit lasts DIV+1 cycles.
- A DIV write mid-bit takes effect at the next bit start.
- IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register, drive `tx`=0, and go to START.
- START: after one bit period, drive `tx`=shift[0] and go to DATA with bit index 0.
- DATA: 8 bits, LSB first. After bit 7, drive `tx`=1 and go to STOP.
- STOP: after one bit period:
  - if the FIFO is non-empty, pop, drive `tx`=0, and go to START (frames are back-to-back with no gap);
  - otherwise go to IDLE.
- `tx` is registered and glitch-free.

Reset (async, any time, including mid-frame):
- `tx`=1, `rdata`=0, `rvalid`=0, `idle`=1.
- FIFO is emptied, `ovf`=0, DIV=`DIV_RESET`, FSM goes to IDLE.

## Timing
- Access sampled at edge N: register and FIFO updates complete at N.
- Reads: `rdata`/`rvalid` are valid in the cycle after edge N. `rvalid` stays high for exactly 1 cycle. STATUS shows the pre-edge-N state.
- Write to an empty FIFO with the FSM in IDLE at edge N:
  - pop at edge N+1, where `tx` falls;
  - frame length is 10·(DIV+1) cycles;
  - `idle` returns high at the end of STOP if no further data is queued.
- `deven` on consecutive cycles is legal. Every access is serviced and there is no backpressure.

## Test plan
- Reset, then write 0x55 to DATA with DIV=3:
  - `tx` falls one cycle later;
  - `tx` then reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit exactly 4 cycles;
  - `idle` is high 40 cycles after the fall.
- Write 0xA5, 0x01, 0xFF back-to-back, DIV=1: three contiguous 20-cycle frames, no idle cycle between stop and the next start.
- FIFO_DEPTH=4, DIV=100, 6 rapid DATA writes:
  - first byte popped, next 4 queued, 6th dropped;
  - STATUS reads full=1, ovf=1;
  - write 0x8 to STATUS clears `ovf`; `full` is unaffected.
- Read DIV after reset: `rdata`=433, `rvalid` one cycle. Write 0x1234 to DIV, read back 0x1234. Read offset 0xC returns 0.
- Assert `n_rst` low mid-data-bit:
  - `tx`=1 immediately (async);
  - after release, STATUS=0x2 and DIV=433;
  - no further frame is transmitted.
- DIV changed from 9 to 2 mid-bit: the current bit keeps 10 cycles; subsequent bits are 3 cycles.
